// File: rtl/kl10_diag_pkg.sv
// kl10_diag_pkg: shared definitions for the KL10 diagnostic EBUS masters.
// Holds diag function codes, the dram_loader state encoding and the DRAM
// entry field widths.
//
// Bit numbering: the KL10 numbers bits MSB-first (bit 0 is the most
// significant). Vectors here are declared [W-1:0], so KL10 bit i of a W-bit
// field lives at index W-1-i. Numeric values are identical either way.
package kl10_diag_pkg;

  // DRAM entry field widths and bus widths
  localparam int DRAM_ADDR_W = 9;
  localparam int DRAM_AB_W   = 3;
  localparam int DRAM_J_W    = 4;
  localparam int IR_W        = 13;
  localparam int EBUS_W      = 36;
  localparam int DIAG_FUNC_W = 9;

  // Diag function codes: five DRAM load functions and two readback functions
  localparam logic [DIAG_FUNC_W-1:0] DIAG_LD_XY_EVEN = 9'o060;
  localparam logic [DIAG_FUNC_W-1:0] DIAG_LD_XY_ODD  = 9'o061;
  localparam logic [DIAG_FUNC_W-1:0] DIAG_LD_J_COM   = 9'o062;
  localparam logic [DIAG_FUNC_W-1:0] DIAG_LD_J_EVEN  = 9'o063;
  localparam logic [DIAG_FUNC_W-1:0] DIAG_LD_J_ODD   = 9'o064;
  localparam logic [DIAG_FUNC_W-1:0] DIAG_RD_130     = 9'o130;
  localparam logic [DIAG_FUNC_W-1:0] DIAG_RD_131     = 9'o131;

  // dram_loader sequencer states
  typedef enum logic [2:0] {
    DL_IDLE   = 3'd0,
    DL_ADDR   = 3'd1,
    DL_DRADR  = 3'd2,
    DL_SETUP  = 3'd3,
    DL_STROBE = 3'd4,
    DL_READ   = 3'd5,
    DL_DONE   = 3'd6
  } dl_state_e;

  // Phase index k -> diag function code (0..4 loads, 5..6 readbacks)
  function automatic logic [DIAG_FUNC_W-1:0] diag_func_for(input logic [2:0] k);
    logic [DIAG_FUNC_W-1:0] f;
    case (k)
      3'd0:    f = DIAG_LD_XY_EVEN;
      3'd1:    f = DIAG_LD_XY_ODD;
      3'd2:    f = DIAG_LD_J_COM;
      3'd3:    f = DIAG_LD_J_EVEN;
      3'd4:    f = DIAG_LD_J_ODD;
      3'd5:    f = DIAG_RD_130;
      3'd6:    f = DIAG_RD_131;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dram_entry_pack.sv
// dram_entry_pack: combinational EBUS packer for the five DRAM load
// functions. Given phase index k and the captured entry fields it produces
// the 36-bit EBUS word and the even/odd entry parity bits.
// Parity is chosen so each full entry (A, B, J common, J low, P) has odd parity.
module dram_entry_pack
  import kl10_diag_pkg::*;
(
  input  logic [2:0]           k,
  input  logic [DRAM_AB_W-1:0] even_a,
  input  logic [DRAM_AB_W-1:0] even_b,
  input  logic [DRAM_AB_W-1:0] odd_a,
  input  logic [DRAM_AB_W-1:0] odd_b,
  input  logic [DRAM_J_W-1:0]  j_common,
  input  logic [DRAM_J_W-1:0]  j_even,
  input  logic [DRAM_J_W-1:0]  j_odd,
  output logic [EBUS_W-1:0]    ebus,
  output logic                 par_even,
  output logic                 par_odd
);

  assign par_even = ~^{even_a, even_b, j_common, j_even};
  assign par_odd  = ~^{odd_a, odd_b, j_common, j_odd};

  // Place the selected fields at their KL10 EBUS bit positions; all else 0
  always_comb begin
    ebus = '0;
    case (k)
      3'd0: begin                // EBUS 0:2 = A, 3:5 = B, 6 = P (even)
        ebus[35:33] = even_a;
        ebus[32:30] = even_b;
        ebus[29]    = par_even;
      end
      3'd1: begin                // same layout, odd entry
        ebus[35:33] = odd_a;
        ebus[32:30] = odd_b;
        ebus[29]    = par_odd;
      end
      3'd2: ebus[34:31] = j_common;   // EBUS 1:4
      3'd3: ebus[33:30] = j_even;     // EBUS 2:5
      3'd4: ebus[33:30] = j_odd;      // EBUS 2:5
      default: ebus = '0;
    endcase
  end

endmodule

// File: rtl/dram_loader.sv
// dram_loader: diagnostic-side writer for the IR board dispatch RAM.
// Captures one even/odd DRAM entry pair on start, latches the pair address
// through IR and DRADR, then issues diag functions 060..064 over EBUS, each
// as SETUP_CYCLES of stable data followed by STROBE_CYCLES of diagStrobe.
//
// Optional feature macro: DRAM_LOADER_VERIFY_EN
//   Adds two readback phases (functions 130, 131) before DONE, compares the
//   returned address bits against the captured address and sets a sticky
//   error on mismatch. Undefined: diagRead and error are tied low.
//
// Vectors are [W-1:0]; KL10 bit i of a W-bit field is index W-1-i.
module dram_loader
  import kl10_diag_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   start,
  input  logic [DRAM_ADDR_W-1:0] dramAddr,
  input  logic [DRAM_AB_W-1:0]   evenA,
  input  logic [DRAM_AB_W-1:0]   evenB,
  input  logic [DRAM_AB_W-1:0]   oddA,
  input  logic [DRAM_AB_W-1:0]   oddB,
  input  logic [DRAM_J_W-1:0]    jCommon,
  input  logic [DRAM_J_W-1:0]    jEven,
  input  logic [DRAM_J_W-1:0]    jOdd,
  input  logic [EBUS_W-1:0]      ebusIn,
  output logic                   busy,
  output logic                   done,
  output logic [IR_W-1:0]        irData,
  output logic                   loadIR,
  output logic                   loadDRAM,
  output logic [DIAG_FUNC_W-1:0] diagFunc,
  output logic                   diagStrobe,
  output logic                   diagRead,
  output logic                   ebusDrive,
  output logic [EBUS_W-1:0]      ebusOut,
  output logic                   error
);

  localparam logic [2:0] ST_IDLE   = DL_IDLE;
  localparam logic [2:0] ST_ADDR   = DL_ADDR;
  localparam logic [2:0] ST_DRADR  = DL_DRADR;
  localparam logic [2:0] ST_SETUP  = DL_SETUP;
  localparam logic [2:0] ST_STROBE = DL_STROBE;
  localparam logic [2:0] ST_READ   = DL_READ;
  localparam logic [2:0] ST_DONE   = DL_DONE;

  localparam int MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int CYC_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CYC_W-1:0] SETUP_LAST  = CYC_W'(SETUP_CYCLES - 1);
  localparam logic [CYC_W-1:0] STROBE_LAST = CYC_W'(STROBE_CYCLES - 1);

  // Phase index: 0..4 are EBUS loads, 5..6 (verify only) are readbacks
  localparam logic [2:0] K_LAST_WRITE = 3'd4;
`ifdef DRAM_LOADER_VERIFY_EN
  localparam logic [2:0] K_RD_FIRST   = 3'd5;
  localparam logic [2:0] K_LAST       = 3'd6;
`else
  localparam logic [2:0] K_LAST       = 3'd4;
`endif

  logic [2:0]       state_reg, state_next;
  logic [2:0]       k_reg, k_next;
  logic [CYC_W-1:0] cyc_reg, cyc_next;

  // Captured entry; the address keeps only KL10 bits 0..7 (bit 8 is forced 0)
  logic [7:0]           addr_reg;
  logic [DRAM_AB_W-1:0] even_a_reg, even_b_reg, odd_a_reg, odd_b_reg;
  logic [DRAM_J_W-1:0]  j_common_reg, j_even_reg, j_odd_reg;

  logic              accept;
  logic              in_phase;
  logic              write_phase;
  logic [EBUS_W-1:0] pack_ebus;
  logic              par_even_unused, par_odd_unused;
  logic              addr_lsb_unused;

  assign accept          = (state_reg == ST_IDLE) && start;
  assign addr_lsb_unused = dramAddr[0];

  // Sequencer registers; async reset abandons any partial write
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      cyc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      cyc_reg   <= cyc_next;
    end
  end

  // Capture all data inputs on the accepted start; later changes are ignored
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addr_reg     <= '0;
      even_a_reg   <= '0;
      even_b_reg   <= '0;
      odd_a_reg    <= '0;
      odd_b_reg    <= '0;
      j_common_reg <= '0;
      j_even_reg   <= '0;
      j_odd_reg    <= '0;
    end else if (accept) begin
      addr_reg     <= dramAddr[8:1];
      even_a_reg   <= evenA;
      even_b_reg   <= evenB;
      odd_a_reg    <= oddA;
      odd_b_reg    <= oddB;
      j_common_reg <= jCommon;
      j_even_reg   <= jEven;
      j_odd_reg    <= jOdd;
    end
  end

  // Next-state: address latch, then SETUP/STROBE (or SETUP/READ) per phase
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    cyc_next   = cyc_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_ADDR;
          k_next     = '0;
          cyc_next   = '0;
        end
      end
      ST_ADDR:  state_next = ST_DRADR;
      ST_DRADR: begin
        state_next = ST_SETUP;
        k_next     = '0;
        cyc_next   = '0;
      end
      ST_SETUP: begin
        if (cyc_reg == SETUP_LAST) begin
          cyc_next   = '0;
          state_next = (k_reg > K_LAST_WRITE) ? ST_READ : ST_STROBE;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      ST_STROBE, ST_READ: begin
        if (cyc_reg == STROBE_LAST) begin
          cyc_next = '0;
          if (k_reg == K_LAST) begin
            state_next = ST_DONE;
          end else begin
            k_next     = k_reg + 3'd1;
            state_next = ST_SETUP;
          end
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  dram_entry_pack u_pack (
    .k        (k_reg),
    .even_a   (even_a_reg),
    .even_b   (even_b_reg),
    .odd_a    (odd_a_reg),
    .odd_b    (odd_b_reg),
    .j_common (j_common_reg),
    .j_even   (j_even_reg),
    .j_odd    (j_odd_reg),
    .ebus     (pack_ebus),
    .par_even (par_even_unused),
    .par_odd  (par_odd_unused)
  );

  assign in_phase    = (state_reg == ST_SETUP) || (state_reg == ST_STROBE) ||
                       (state_reg == ST_READ);
  assign write_phase = in_phase && (k_reg <= K_LAST_WRITE);

  // Moore output decode; IDLE and DONE present an idle bus
  always_comb begin
    busy       = (state_reg != ST_IDLE);
    done       = (state_reg == ST_DONE);
    loadIR     = (state_reg == ST_ADDR);
    loadDRAM   = (state_reg == ST_DRADR);
    irData     = '0;
    if ((state_reg == ST_ADDR) || (state_reg == ST_DRADR)) begin
      irData = {addr_reg, 1'b0, 4'b0000};
    end
    diagFunc   = in_phase ? diag_func_for(k_reg) : '0;
    diagStrobe = (state_reg == ST_STROBE);
    ebusDrive  = write_phase;
    ebusOut    = write_phase ? pack_ebus : '0;
  end

`ifdef DRAM_LOADER_VERIFY_EN
  logic error_reg;
  logic read_last;
  logic read_mismatch;
  logic ebus_in_unused;

  assign read_last      = (state_reg == ST_READ) && (cyc_reg == STROBE_LAST);
  assign ebus_in_unused = ^ebusIn[29:0];

  // 130 returns address bits 0:2 on EBUS 3:5; 131 returns bits 3:7,0 on EBUS 0:5
  always_comb begin
    read_mismatch = 1'b0;
    if (k_reg == K_RD_FIRST) begin
      read_mismatch = (ebusIn[32:30] != addr_reg[7:5]);
    end else begin
      read_mismatch = (ebusIn[35:30] != {addr_reg[4:0], 1'b0});
    end
  end

  // Sticky readback error, cleared when the next request is accepted
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      error_reg <= 1'b0;
    end else if (accept) begin
      error_reg <= 1'b0;
    end else if (read_last && read_mismatch) begin
      error_reg <= 1'b1;
    end
  end

  assign diagRead = (state_reg == ST_READ);
  assign error    = error_reg;
`else
  logic ebus_in_unused;
  assign ebus_in_unused = ^ebusIn;
  assign diagRead       = 1'b0;
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_dram_loader.sv
// tb_dram_loader: directed bench for dram_loader. One default instance and
// one with SETUP_CYCLES=3, STROBE_CYCLES=1; a select chooses which one the
// per-cycle monitor observes. Honours DRAM_LOADER_VERIFY_EN.
module tb_dram_loader;

`ifdef DRAM_LOADER_VERIFY_EN
  localparam int VX = 1;
`else
  localparam int VX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_d = 1'b0, start_p = 1'b0;
  logic        sel = 1'b0;
  logic [8:0]  dram_addr;
  logic [2:0]  even_a, even_b, odd_a, odd_b;
  logic [3:0]  j_common, j_even, j_odd;
  logic [35:0] ebus_in = '0;

  logic        busy_d, done_d, ld_ir_d, ld_dram_d, strobe_d, read_d, drive_d, error_d;
  logic [12:0] ir_d;
  logic [8:0]  func_d;
  logic [35:0] ebus_d;
  logic        busy_p, done_p, ld_ir_p, ld_dram_p, strobe_p, read_p, drive_p, error_p;
  logic [12:0] ir_p;
  logic [8:0]  func_p;
  logic [35:0] ebus_p;

  always #5 clk = ~clk;

  dram_loader dut (
    .clk(clk), .resetN(rst_n), .start(start_d), .dramAddr(dram_addr),
    .evenA(even_a), .evenB(even_b), .oddA(odd_a), .oddB(odd_b),
    .jCommon(j_common), .jEven(j_even), .jOdd(j_odd), .ebusIn(ebus_in),
    .busy(busy_d), .done(done_d), .irData(ir_d), .loadIR(ld_ir_d),
    .loadDRAM(ld_dram_d), .diagFunc(func_d), .diagStrobe(strobe_d),
    .diagRead(read_d), .ebusDrive(drive_d), .ebusOut(ebus_d), .error(error_d)
  );

  dram_loader #(.SETUP_CYCLES(3), .STROBE_CYCLES(1)) dut_p (
    .clk(clk), .resetN(rst_n), .start(start_p), .dramAddr(dram_addr),
    .evenA(even_a), .evenB(even_b), .oddA(odd_a), .oddB(odd_b),
    .jCommon(j_common), .jEven(j_even), .jOdd(j_odd), .ebusIn(ebus_in),
    .busy(busy_p), .done(done_p), .irData(ir_p), .loadIR(ld_ir_p),
    .loadDRAM(ld_dram_p), .diagFunc(func_p), .diagStrobe(strobe_p),
    .diagRead(read_p), .ebusDrive(drive_p), .ebusOut(ebus_p), .error(error_p)
  );

  // Monitor view of the selected instance
  wire        m_busy   = sel ? busy_p    : busy_d;
  wire        m_done   = sel ? done_p    : done_d;
  wire        m_ld_ir  = sel ? ld_ir_p   : ld_ir_d;
  wire        m_ld_dr  = sel ? ld_dram_p : ld_dram_d;
  wire        m_strobe = sel ? strobe_p  : strobe_d;
  wire        m_read   = sel ? read_p    : read_d;
  wire        m_drive  = sel ? drive_p   : drive_d;
  wire        m_error  = sel ? error_p   : error_d;
  wire [12:0] m_ir     = sel ? ir_p      : ir_d;
  wire [8:0]  m_func   = sel ? func_p    : func_d;
  wire [35:0] m_ebus   = sel ? ebus_p    : ebus_d;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-run observations
  int          ir_cyc, dr_cyc, n_strobe, n_read, r_cycles, n_done, done_cyc;
  int          overlap, busy_bad, hold_bad, bus_bad;
  logic [12:0] ir_val, dr_ir, ir_after;
  logic        err_c1, err_after;
  logic [63:0] idle_snap;
  logic [8:0]  s_func  [8];
  logic [35:0] s_ebus  [8];
  int          s_width [8];
  int          s_setup [8];

  logic [8:0]  exp_func [5];
  logic [35:0] exp_ebus [5];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data_a(input logic [8:0] addr);
    dram_addr = addr;
    even_a = 3'o5; even_b = 3'o2; odd_a = 3'o3; odd_b = 3'o6;
    j_common = 4'hA; j_even = 4'h3; j_odd = 4'h5;
  endtask

  // Pulse start on the selected instance at cycle 0, then observe cycles 1..max_cyc
  task automatic run(input int max_cyc, input bit inject, input bit bad_model);
    int          setup_run = 0;
    logic        prev_strobe = 1'b0, prev_read = 1'b0;
    logic [8:0]  last_func = '0;
    logic [35:0] last_ebus = '0;
    ir_cyc = -1; dr_cyc = -1; n_strobe = 0; n_read = 0; r_cycles = 0;
    n_done = 0; done_cyc = -1; overlap = 0; busy_bad = 0; hold_bad = 0; bus_bad = 0;
    ir_val = '0; dr_ir = '0; ir_after = '1; err_c1 = 1'bx; err_after = 1'bx;
    idle_snap = '1;
    @(negedge clk);
    if (sel) start_p = 1'b1; else start_d = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start_d = 1'b0; start_p = 1'b0;
      if (inject && c == 5) begin
        dram_addr = 9'o777; even_a = 3'o0; even_b = 3'o7; odd_a = 3'o7; odd_b = 3'o1;
        j_common = 4'h1; j_even = 4'hC; j_odd = 4'hE;
        if (sel) start_p = 1'b1; else start_d = 1'b1;
      end
      if (c == 1) err_c1 = m_error;
      if (c == 3) ir_after = m_ir;
      if (m_ld_ir) begin ir_cyc = c; ir_val = m_ir; end
      if (m_ld_dr) begin dr_cyc = c; dr_ir = m_ir; end
      if (m_strobe && (m_ld_ir || m_ld_dr)) overlap++;
      if (m_read && m_drive) bus_bad++;
      if (m_strobe) begin
        if (!prev_strobe) begin
          if (n_strobe < 8) begin
            s_func[n_strobe]  = m_func;
            s_ebus[n_strobe]  = m_ebus;
            s_width[n_strobe] = 1;
            s_setup[n_strobe] = (m_func == last_func && m_ebus == last_ebus) ? setup_run : 0;
          end
          n_strobe++;
        end else begin
          if (n_strobe <= 8) s_width[n_strobe-1]++;
          if (m_func != last_func || m_ebus != last_ebus) hold_bad++;
        end
        setup_run = 0;
      end else if (m_drive && !m_read) begin
        setup_run = (setup_run > 0 && m_func == last_func && m_ebus == last_ebus) ? setup_run + 1 : 1;
      end else begin
        setup_run = 0;
      end
      if (m_read) begin
        r_cycles++;
        if (!prev_read) n_read++;
      end
      if (m_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc < 0 || done_cyc == c) begin
        if (!m_busy) busy_bad++;
      end else if (c == done_cyc + 1) begin
        idle_snap = {4'b0, m_busy, m_done, m_ld_ir, m_ld_dr, m_strobe, m_read, m_drive, m_func, m_ebus, m_ir[8:0]};
        err_after = m_error;
      end
      prev_strobe = m_strobe;
      prev_read   = m_read;
      last_func   = m_func;
      last_ebus   = m_ebus;
      // EBUS readback model for captured address 9'o254
      ebus_in = '0;
      if (m_func == 9'o130) ebus_in = {6'o02, 30'd0};
      if (m_func == 9'o131) ebus_in = {6'o54, 30'd0};
      if (bad_model && (m_func == 9'o130 || m_func == 9'o131)) ebus_in[35] = ~ebus_in[35];
    end
  endtask

  task automatic check_run(input string tag, input logic [12:0] exp_ir, input int exp_width,
                           input int exp_setup, input int exp_done, input int exp_rcyc);
    check_eq({tag, "_ir_cyc"}, ir_cyc, 1);
    check_eq({tag, "_ir_val"}, ir_val, exp_ir);
    check_eq({tag, "_dradr_cyc"}, dr_cyc, 2);
    check_eq({tag, "_dradr_ir"}, dr_ir, exp_ir);
    check_eq({tag, "_ir_after"}, ir_after, 0);
    check_eq({tag, "_n_strobe"}, n_strobe, 5);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("%s_func%0d", tag, k), s_func[k], exp_func[k]);
      check_eq($sformatf("%s_ebus%0d", tag, k), s_ebus[k], exp_ebus[k]);
      check_eq($sformatf("%s_width%0d", tag, k), s_width[k], exp_width);
      check_eq($sformatf("%s_setup%0d", tag, k), s_setup[k], exp_setup);
    end
    check_eq({tag, "_done_cyc"}, done_cyc, exp_done);
    check_eq({tag, "_n_done"}, n_done, 1);
    check_eq({tag, "_strobe_overlap"}, overlap, 0);
    check_eq({tag, "_busy_gap"}, busy_bad, 0);
    check_eq({tag, "_hold"}, hold_bad, 0);
    check_eq({tag, "_idle_after"}, idle_snap, 0);
    check_eq({tag, "_n_read"}, n_read, 2 * VX);
    check_eq({tag, "_read_cycles"}, r_cycles, exp_rcyc);
    check_eq({tag, "_read_drive"}, bus_bad, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    exp_func[0] = 9'o060; exp_func[1] = 9'o061; exp_func[2] = 9'o062;
    exp_func[3] = 9'o063; exp_func[4] = 9'o064;
    // Pe: 5,2,A,3 hold 7 ones -> Pe=0; Po: 3,6,A,5 hold 8 ones -> Po=1
    exp_ebus[0] = {3'o5, 3'o2, 1'b0, 29'd0};
    exp_ebus[1] = {3'o3, 3'o6, 1'b1, 29'd0};
    exp_ebus[2] = {1'b0, 4'hA, 31'd0};
    exp_ebus[3] = {2'b0, 4'h3, 30'd0};
    exp_ebus[4] = {2'b0, 4'h5, 30'd0};
    set_data_a(9'o254);

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {busy_d, done_d, ld_ir_d, ld_dram_d, strobe_d, read_d, drive_d, error_d}, 0);
    check_eq("rst_ir", ir_d, 0);
    check_eq("rst_func", func_d, 0);
    check_eq("rst_ebus", ebus_d, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write
    sel = 1'b0;
    run(30, 1'b0, 1'b0);
    check_run("basic", 13'o05300, 2, 1, 18 + 6 * VX, 4 * VX);
    check_eq("basic_error", err_after, 0);

    // Odd address bit is dropped
    set_data_a(9'o255);
    run(30, 1'b0, 1'b0);
    check_run("oddaddr", 13'o05300, 2, 1, 18 + 6 * VX, 4 * VX);
    check_eq("oddaddr_error", err_after, 0);

    // Start during a sequence is ignored; captured data is used
    set_data_a(9'o254);
    run(30, 1'b1, 1'b0);
    check_run("busystart", 13'o05300, 2, 1, 18 + 6 * VX, 4 * VX);
    set_data_a(9'o254);

    // Reset during the k=2 strobe
    @(negedge clk); start_d = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_d = 1'b0;
    end
    check_eq("rmid_strobe_k2", {strobe_d, func_d}, {1'b1, 9'o062});
    rst_n = 1'b0;
    #1;
    check_eq("rmid_ctrl", {busy_d, done_d, ld_ir_d, ld_dram_d, strobe_d, read_d, drive_d, error_d}, 0);
    check_eq("rmid_data", {ir_d, func_d, ebus_d}, 0);
    @(negedge clk); rst_n = 1'b1;
    run(30, 1'b0, 1'b0);
    check_run("afterrst", 13'o05300, 2, 1, 18 + 6 * VX, 4 * VX);

    // SETUP_CYCLES=3, STROBE_CYCLES=1
    sel = 1'b1;
    run(40, 1'b0, 1'b0);
    check_run("params", 13'o05300, 1, 3, 23 + 8 * VX, 2 * VX);
    sel = 1'b0;

`ifdef DRAM_LOADER_VERIFY_EN
    // Bad readback sets error; next accepted start clears it
    run(30, 1'b0, 1'b1);
    check_eq("verify_bad_done", done_cyc, 24);
    check_eq("verify_bad_error", err_after, 1);
    run(30, 1'b0, 1'b0);
    check_eq("verify_clear_c1", err_c1, 0);
    check_eq("verify_good_error", err_after, 0);
    check_eq("verify_good_done", done_cyc, 24);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
